axis_dsm_osr_ctrl: RTL and testbench

AXIS_DSM_OSR_CTRL -- requirements
Module: axis_dsm_osr_ctrl

---
 rtl/dsm_dac_pkg.sv | 17 +
 rtl/dsm_frame_timer.sv | 38 +++
 rtl/axis_dsm_osr_ctrl.sv | 118 +++++++++++
 tb/tb_axis_dsm_osr_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dsm_dac_pkg.sv
// Shared types for the DSM DAC sample-rate controller.
// Holds the state encoding and the attenuation-shift width helper.
package dsm_dac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } dsm_state_e;

  // A zero-bit shift amount is not legal, so never return less than 1.
  function automatic int atten_w(input int atten_max);
    return (atten_max < 1) ? 1 : $clog2(atten_max + 1);
  endfunction

endpackage

// File: rtl/dsm_frame_timer.sv
// Frame position counter: counts beats 0..osr_l-1, latching the ratio at frame start.
// Latency 0 for frame_start/frame_end; advances only on beats, so it freezes under backpressure.
module dsm_frame_timer #(
  parameter int OSR_W = 8
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             clr,
  input  logic             beat,
  input  logic [OSR_W-1:0] cfg_osr,
  output logic             frame_start,
  output logic             frame_end
);

  logic [OSR_W-1:0] frame_cnt;
  logic [OSR_W-1:0] osr_q;
  logic [OSR_W-1:0] osr_eff;
  logic [OSR_W-1:0] osr_cur;

  assign osr_eff     = (cfg_osr == '0) ? OSR_W'(1) : cfg_osr;
  assign frame_start = (frame_cnt == '0);
  // On the first beat of a frame the live ratio applies; afterwards the latched one.
  assign osr_cur     = frame_start ? osr_eff : osr_q;
  assign frame_end   = beat && (frame_cnt == (osr_cur - OSR_W'(1)));

  always_ff @(posedge aclk) begin
    if (arst || clr) begin
      frame_cnt <= '0;
      osr_q     <= OSR_W'(1);
    end else if (beat) begin
      if (frame_start) begin
        osr_q <= osr_eff;
      end
      frame_cnt <= frame_end ? '0 : (frame_cnt + OSR_W'(1));
    end
  end

endmodule

// File: rtl/axis_dsm_osr_ctrl.sv
// Feeds a DSM DAC one sample per cycle, upsampling by zero-order hold with a click-free volume ramp.
// Output latency 1 cycle after input handshake; input ready only at frame start while the DAC side is ready.
module axis_dsm_osr_ctrl
  import dsm_dac_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OSR_W     = 8,
  parameter int ATTEN_MAX = WIDTH - 1
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             cfg_enable,
  input  logic [OSR_W-1:0] cfg_osr,
  input  logic [WIDTH-1:0] s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic             busy,
  output logic [15:0]      underrun_cnt
);

  localparam int            AW        = atten_w(ATTEN_MAX);
  localparam logic [AW-1:0] ATTEN_TOP = AW'(ATTEN_MAX);

  dsm_state_e              state_q, state_d;
  logic [AW-1:0]           atten_q, atten_d;
  logic signed [WIDTH-1:0] hold_q;
  logic [15:0]             underrun_q;
  logic                    beat;
  logic                    s_hs;
  logic                    frame_start;
  logic                    frame_end;
  logic                    underrun_evt;

  assign m_axis_data_tvalid = (state_q != IDLE);
  assign busy               = (state_q != IDLE);
  assign beat               = m_axis_data_tvalid && m_axis_data_tready;
  assign s_axis_data_tready = (state_q != IDLE) && frame_start && m_axis_data_tready;
  assign s_hs               = s_axis_data_tready && s_axis_data_tvalid;
  assign underrun_evt       = (state_q == RUN) && beat && frame_start && !s_axis_data_tvalid;
  assign m_axis_data_tdata  = hold_q >>> atten_q;
  assign underrun_cnt       = underrun_q;

  dsm_frame_timer #(
    .OSR_W (OSR_W)
  ) u_frame_timer (
    .aclk        (aclk),
    .arst        (arst),
    .clr         (state_d == IDLE),
    .beat        (beat),
    .cfg_osr     (cfg_osr),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  // An enable change always wins over a ramp step landing on the same cycle.
  always_comb begin
    state_d = state_q;
    atten_d = atten_q;
    case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          state_d = RAMP_UP;
          atten_d = ATTEN_TOP;
        end
      end
      RAMP_UP: begin
        if (!cfg_enable) begin
          state_d = RAMP_DOWN;
        end else if (frame_end) begin
          if (atten_q == '0) state_d = RUN;
          else               atten_d = atten_q - AW'(1);
        end
      end
      RUN: begin
        if (!cfg_enable) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (cfg_enable) begin
          state_d = RAMP_UP;
        end else if (frame_end) begin
          if (atten_q == ATTEN_TOP) state_d = IDLE;
          else                      atten_d = atten_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= IDLE;
      atten_q <= ATTEN_TOP;
    end else begin
      state_q <= state_d;
      atten_q <= atten_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst || (state_d == IDLE)) begin
      hold_q <= '0;
    end else if (s_hs) begin
      hold_q <= s_axis_data_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      underrun_q <= '0;
    end else if (underrun_evt && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_dsm_osr_ctrl.sv
// Directed bench for axis_dsm_osr_ctrl: ramps, streaming, underrun, stall and reset scenarios.
module tb_axis_dsm_osr_ctrl;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_osr = 8'd0;
  logic [15:0] s_tdata = 16'h0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        busy;
  logic [15:0] underrun_cnt;

  int nvec = 0;
  int nerr = 0;

  axis_dsm_osr_ctrl dut (
    .aclk               (aclk),
    .arst               (arst),
    .cfg_enable         (cfg_enable),
    .cfg_osr            (cfg_osr),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .busy               (busy),
    .underrun_cnt       (underrun_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; cfg_enable = 1'b0; m_tready = 1'b1; s_tvalid = 1'b1;
    step(); step();
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    nvec++; if (m_tdata !== 16'h0) begin nerr++; $display("FAIL rst_tdata got %h want 0000", m_tdata); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
    nvec++; if (s_tready !== 1'b0) begin nerr++; $display("FAIL rst_tready got %b want 0", s_tready); end
    nvec++; if (underrun_cnt !== 16'h0) begin nerr++; $display("FAIL rst_underrun got %h want 0000", underrun_cnt); end
    arst = 1'b0;
    step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_ramp_up();
    logic [15:0] exp;
    cfg_osr = 8'd4; s_tdata = 16'h4000; s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    step();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL up_busy got %b want 1", busy); end
    nvec++; if (m_tvalid !== 1'b1) begin nerr++; $display("FAIL up_tvalid got %b want 1", m_tvalid); end
    nvec++; if (s_tready !== 1'b1) begin nerr++; $display("FAIL up_tready0 got %b want 1", s_tready); end
    nvec++; if (m_tdata !== 16'h0) begin nerr++; $display("FAIL up_tdata0 got %h want 0000", m_tdata); end
    for (int b = 1; b <= 64; b++) begin
      step();
      nvec++;
      if (s_tready !== (b % 4 == 0)) begin
        nerr++; $display("FAIL up_tready beat %0d got %b want %b", b, s_tready, (b % 4 == 0));
      end
      if ((b % 4 == 0) && (b <= 60)) begin
        exp = 16'h4000 >> (15 - b / 4);
        nvec++;
        if (m_tdata !== exp) begin nerr++; $display("FAIL up_level beat %0d got %h want %h", b, m_tdata, exp); end
      end
      if (b == 60) s_tvalid = 1'b0;
      if (b == 61) s_tvalid = 1'b1;
    end
    nvec++; if (underrun_cnt !== 16'h0) begin nerr++; $display("FAIL up_no_underrun got %h want 0000", underrun_cnt); end
    nvec++; if (m_tdata !== 16'h4000) begin nerr++; $display("FAIL up_run_tdata got %h want 4000", m_tdata); end
  endtask

  task automatic test_run_stream();
    s_tdata = 16'h1000;
    nvec++; if (s_tready !== 1'b1) begin nerr++; $display("FAIL run_tready0 got %b want 1", s_tready); end
    step();
    nvec++; if (m_tdata !== 16'h1000) begin nerr++; $display("FAIL run_step1 got %h want 1000", m_tdata); end
    nvec++; if (s_tready !== 1'b0) begin nerr++; $display("FAIL run_tready1 got %b want 0", s_tready); end
    s_tdata = 16'h2000;
    for (int i = 2; i <= 4; i++) begin
      step();
      nvec++;
      if (m_tdata !== 16'h1000) begin nerr++; $display("FAIL run_hold cyc %0d got %h want 1000", i, m_tdata); end
    end
    nvec++; if (s_tready !== 1'b1) begin nerr++; $display("FAIL run_tready4 got %b want 1", s_tready); end
    step();
    nvec++; if (m_tdata !== 16'h2000) begin nerr++; $display("FAIL run_step2 got %h want 2000", m_tdata); end
    step(); step(); step();
  endtask

  task automatic test_underrun();
    s_tvalid = 1'b0; s_tdata = 16'h7777;
    repeat (12) step();
    nvec++; if (m_tdata !== 16'h2000) begin nerr++; $display("FAIL ur_hold got %h want 2000", m_tdata); end
    nvec++; if (underrun_cnt !== 16'd3) begin nerr++; $display("FAIL ur_count got %0d want 3", underrun_cnt); end
  endtask

  task automatic test_backpressure();
    cfg_osr = 8'd0; m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = 16'h5555;
    #1;
    for (int i = 0; i < 10; i++) begin
      nvec++; if (s_tready !== 1'b0) begin nerr++; $display("FAIL bp_tready cyc %0d got %b want 0", i, s_tready); end
      step();
    end
    nvec++; if (m_tvalid !== 1'b1) begin nerr++; $display("FAIL bp_tvalid got %b want 1", m_tvalid); end
    nvec++; if (m_tdata !== 16'h2000) begin nerr++; $display("FAIL bp_tdata got %h want 2000", m_tdata); end
    nvec++; if (underrun_cnt !== 16'd3) begin nerr++; $display("FAIL bp_underrun got %0d want 3", underrun_cnt); end
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 16'h1234;
    #1;
    nvec++; if (s_tready !== 1'b1) begin nerr++; $display("FAIL bp_resume_tready got %b want 1", s_tready); end
    step();
    nvec++; if (m_tdata !== 16'h1234) begin nerr++; $display("FAIL bp_osr1_a got %h want 1234", m_tdata); end
    s_tdata = 16'h0567;
    nvec++; if (s_tready !== 1'b1) begin nerr++; $display("FAIL bp_osr1_tready got %b want 1", s_tready); end
    step();
    nvec++; if (m_tdata !== 16'h0567) begin nerr++; $display("FAIL bp_osr1_b got %h want 0567", m_tdata); end
    s_tvalid = 1'b0;
    step();
    nvec++; if (underrun_cnt !== 16'd4) begin nerr++; $display("FAIL bp_osr1_underrun got %0d want 4", underrun_cnt); end
  endtask

  task automatic test_saturate();
    repeat (65530) step();
    nvec++; if (underrun_cnt !== 16'hFFFE) begin nerr++; $display("FAIL sat_pre got %h want fffe", underrun_cnt); end
    repeat (3) step();
    nvec++; if (underrun_cnt !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold got %h want ffff", underrun_cnt); end
  endtask

  task automatic test_ramp_down();
    arst = 1'b1;
    step();
    nvec++; if (underrun_cnt !== 16'h0) begin nerr++; $display("FAIL rd_rst_underrun got %h want 0000", underrun_cnt); end
    arst = 1'b0; cfg_osr = 8'd4; s_tdata = 16'h4000; s_tvalid = 1'b1; m_tready = 1'b1; cfg_enable = 1'b1;
    step();
    repeat (34) step();
    nvec++; if (m_tdata !== 16'h0080) begin nerr++; $display("FAIL rd_at7 got %h want 0080", m_tdata); end
    cfg_enable = 1'b0;
    step();
    nvec++; if (m_tdata !== 16'h0080) begin nerr++; $display("FAIL rd_enter got %h want 0080", m_tdata); end
    step();
    nvec++; if (m_tdata !== 16'h0040) begin nerr++; $display("FAIL rd_at8 got %h want 0040", m_tdata); end
    repeat (4) step();
    nvec++; if (m_tdata !== 16'h0020) begin nerr++; $display("FAIL rd_at9 got %h want 0020", m_tdata); end
    m_tready = 1'b0;
    repeat (5) step();
    nvec++; if (m_tdata !== 16'h0020) begin nerr++; $display("FAIL rd_stall_level got %h want 0020", m_tdata); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rd_stall_busy got %b want 1", busy); end
    m_tready = 1'b1;
    for (int b = 41; b <= 68; b++) begin
      step();
      if (b == 60) begin
        nvec++; if (m_tdata !== 16'h0001) begin nerr++; $display("FAIL rd_at14 got %h want 0001", m_tdata); end
      end
      if (b == 67) begin
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rd_last_busy got %b want 1", busy); end
      end
    end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rd_idle_busy got %b want 0", busy); end
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL rd_idle_tvalid got %b want 0", m_tvalid); end
    nvec++; if (m_tdata !== 16'h0) begin nerr++; $display("FAIL rd_idle_tdata got %h want 0000", m_tdata); end
    nvec++; if (s_tready !== 1'b0) begin nerr++; $display("FAIL rd_idle_tready got %b want 0", s_tready); end
  endtask

  task automatic test_reset_mid_ramp_down();
    cfg_enable = 1'b1;
    step();
    repeat (8) step();
    nvec++; if (m_tdata !== 16'h0002) begin nerr++; $display("FAIL mr_at13 got %h want 0002", m_tdata); end
    cfg_enable = 1'b0;
    step(); step();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL mr_busy got %b want 1", busy); end
    arst = 1'b1;
    step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mr_rst_busy got %b want 0", busy); end
    nvec++; if (m_tvalid !== 1'b0) begin nerr++; $display("FAIL mr_rst_tvalid got %b want 0", m_tvalid); end
    nvec++; if (m_tdata !== 16'h0) begin nerr++; $display("FAIL mr_rst_tdata got %h want 0000", m_tdata); end
    nvec++; if (s_tready !== 1'b0) begin nerr++; $display("FAIL mr_rst_tready got %b want 0", s_tready); end
    arst = 1'b0;
    step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mr_post_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_run_stream();
    test_underrun();
    test_backpressure();
    test_saturate();
    test_ramp_down();
    test_reset_mid_ramp_down();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d vectors", nvec);
    $fatal(1, "timeout");
  end

endmodule
